// File: rtl/loader_wb_bridge.sv
// Bridges the hps_io download stream onto the SDRAM Wishbone port and shares that port with the core bus.
// Latency: core pass-through is combinational; a loader word reaches ram_stb two edges after its ioctl_wr.
// Backpressure: ioctl_wait rises at FIFO_DEPTH-1 entries; a push into a full FIFO is dropped and flagged.
module loader_wb_bridge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [31:0] ioctl_dout,
    input  logic [3:0]  ioctl_sel,
    output logic        ioctl_wait,
    input  logic        core_stb,
    input  logic        core_cyc,
    input  logic        core_we,
    input  logic [3:0]  core_sel,
    input  logic [21:0] core_adr,
    input  logic [31:0] core_dat_o,
    output logic        core_ack,
    output logic        ram_stb,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [25:0] ram_adr,
    output logic [31:0] ram_dat_o,
    input  logic        ram_ack,
    output logic        loader_busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + 22 + 32;

    typedef enum logic [2:0] {
        ST_CORE,
        ST_DRAIN_CORE,
        ST_LOAD_IDLE,
        ST_LOAD_CYC,
        ST_FLUSH_IDLE,
        ST_FLUSH_CYC
    } state_t;

    state_t        state;

    // FIFO entry layout: {sel, word address [23:2], data}
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;

    // Registered loader beat driven onto ram_* outside the pass-through states
    logic          ld_stb;
    logic          ld_we;
    logic [3:0]    ld_sel;
    logic [25:0]   ld_adr;
    logic [31:0]   ld_dat;

    logic          download_q;
    logic          pass;
    logic          unused_ok;

    // Inputs with no function here: cycle framing comes from core_stb, and
    // the loader only ever addresses the low 16 MB on word boundaries.
    assign unused_ok = ^{core_cyc, ioctl_addr[24], ioctl_addr[1:0]};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];

    // A beat is retired on its ack; a full FIFO still accepts a push in that same cycle.
    assign pop  = ((state == ST_LOAD_CYC) || (state == ST_FLUSH_CYC)) && ram_ack;
    assign push = ioctl_wr && (!fifo_full || pop);
    assign drop = ioctl_wr && fifo_full && !pop;

    // One slot is kept spare for a write hps_io may already have in flight.
    assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ioctl_sel, ioctl_addr[23:2], ioctl_dout};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag, cleared when a new download begins.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            download_q <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            download_q <= ioctl_download;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ioctl_download && !download_q) begin
                overflow <= 1'b0;
            end
        end
    end

    // Port ownership FSM and the registered loader beat.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= ST_CORE;
            loader_busy <= 1'b0;
            ld_stb      <= 1'b0;
            ld_we       <= 1'b0;
            ld_sel      <= '0;
            ld_adr      <= '0;
            ld_dat      <= '0;
        end else begin
            case (state)
                ST_CORE: begin
                    if (ioctl_download) begin
                        loader_busy <= 1'b1;
                        // Let a core cycle already on the bus finish first.
                        if (core_stb && !ram_ack) begin
                            state <= ST_DRAIN_CORE;
                        end else begin
                            state <= ST_LOAD_IDLE;
                        end
                    end
                end
                ST_DRAIN_CORE: begin
                    if (ram_ack) begin
                        state <= ioctl_download ? ST_LOAD_IDLE : ST_FLUSH_IDLE;
                    end
                end
                ST_LOAD_IDLE, ST_FLUSH_IDLE: begin
                    if (ioctl_download && (state == ST_FLUSH_IDLE)) begin
                        state <= ST_LOAD_IDLE;
                    end else if (!ioctl_download && (state == ST_LOAD_IDLE)) begin
                        state <= ST_FLUSH_IDLE;
                    end else if (!fifo_empty) begin
                        ld_stb <= 1'b1;
                        ld_we  <= 1'b1;
                        ld_sel <= head[EW-1 -: 4];
                        ld_adr <= {2'b00, head[53:32], 2'b00};
                        ld_dat <= head[31:0];
                        state  <= (state == ST_LOAD_IDLE) ? ST_LOAD_CYC : ST_FLUSH_CYC;
                    end else if (state == ST_FLUSH_IDLE) begin
                        // Buffer empty and nothing outstanding: hand the bus back.
                        loader_busy <= 1'b0;
                        state       <= ST_CORE;
                    end
                end
                ST_LOAD_CYC, ST_FLUSH_CYC: begin
                    if (ram_ack) begin
                        ld_stb <= 1'b0;
                        ld_we  <= 1'b0;
                        state  <= ioctl_download ? ST_LOAD_IDLE : ST_FLUSH_IDLE;
                    end
                end
                default: begin
                    state <= ST_CORE;
                end
            endcase
        end
    end

    // Core owns the port combinationally; reset forces the loader view so ram_* read as idle.
    assign pass = !reset && ((state == ST_CORE) || (state == ST_DRAIN_CORE));

    // Output mux between core pass-through and the registered loader beat.
    always_comb begin
        ram_stb   = ld_stb;
        ram_cyc   = ld_stb;
        ram_we    = ld_we;
        ram_sel   = ld_sel;
        ram_adr   = ld_adr;
        ram_dat_o = ld_dat;
        core_ack  = 1'b0;
        if (pass) begin
            ram_stb   = core_stb;
            ram_cyc   = core_stb;
            ram_we    = core_we;
            ram_sel   = core_sel;
            ram_adr   = {2'b00, core_adr, 2'b00};
            ram_dat_o = core_dat_o;
            core_ack  = ram_ack;
        end
    end

endmodule
